alg_sequencer: RTL and testbench
================================

ALG_SEQUENCER -- requirements
Module: alg_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 11, ECG sample width; CTR_WIDTH, 22, sample-counter/RR width; TIMEOUT_SAMPLES, 720, forwarded samples without RR update before restart; CORE_RST_CYCLES, 4, core reset pulse length; RES_DEPTH, 4, result FIFO entries (power of 2).
REQ-002 Ports SHALL be, clock and reset first:
- i_clk  in  1  single clock; all logic rising-edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start / i_stop  in  1 each  single-cycle commands.
- i_adc_data  in  DATA_WIDTH signed  raw sample; i_adc_valid in 1; o_adc_ready out 1.
- o_ecg_signal  out  DATA_WIDTH signed  and o_ecg_signal_valid out 1: sample to the detection core.
- o_ctr  out  CTR_WIDTH  sample index to the core.
- o_core_rst  out  1  core reset, active-high.
- o_core_ce  out  1  core clock enable.
- i_th_initialised, i_rr_period_updated  in  1 each; i_rr_period, i_rpeak_location  in  CTR_WIDTH each: core outputs.
- o_res_valid  out 1; i_res_ready  in 1; o_res_rr_period, o_res_rpeak_location  out  CTR_WIDTH each.
- o_busy, o_running, o_timeout, o_overflow  out  1 each; o_restart_cnt  out  8.

Function
REQ-003 FSM SHALL have states IDLE, FLUSH, WARMUP, RUN, RECOVER.
REQ-004 IDLE: o_core_rst=1, o_core_ce=0, o_adc_ready=0; i_start -> FLUSH.
REQ-005 FLUSH and RECOVER SHALL hold o_core_rst=1 for exactly CORE_RST_CYCLES cycles, clear o_ctr and watchdog, then go to WARMUP.
REQ-006 WARMUP: o_core_rst=0, o_core_ce=1, samples forwarded; i_th_initialised=1 -> RUN.
REQ-007 RUN: samples forwarded, RR results captured, watchdog active.
REQ-008 i_stop in any non-IDLE state SHALL go to IDLE next cycle; i_start and i_stop together: stop wins; i_start outside IDLE ignored.
REQ-009 o_adc_ready SHALL be 1 only in WARMUP/RUN and 0 in the cycle after any accepted sample (max one sample per 2 cycles).
REQ-010 On handshake (valid & ready) the sample SHALL appear on o_ecg_signal with o_ecg_signal_valid high for exactly one cycle, 1 cycle latency; o_ecg_signal holds its value otherwise.
REQ-011 o_ctr SHALL increment by 1 in the same cycle o_ecg_signal_valid is high, wrapping 2^CTR_WIDTH-1 -> 0.
REQ-012 Watchdog SHALL count forwarded samples in RUN, clear on i_rr_period_updated (clear wins over simultaneous increment), and on reaching TIMEOUT_SAMPLES go to RECOVER.
REQ-013 Entering RECOVER SHALL pulse o_timeout for one cycle and increment o_restart_cnt, saturating at 255; o_restart_cnt clears on i_start in IDLE.
REQ-014 In RUN, i_rr_period_updated SHALL push {i_rr_period, i_rpeak_location} into the RES_DEPTH FIFO; updates outside RUN are discarded.
REQ-015 FIFO output: valid/ready stream, o_res_valid = not empty, data stable while valid & !ready; pop on valid & ready.
REQ-016 Push when full SHALL be dropped and set sticky o_overflow, unless a pop occurs the same cycle (then both succeed); o_overflow clears on i_start.
REQ-017 FIFO contents SHALL survive RECOVER and IDLE; only i_rst empties it.
REQ-018 o_busy = state != IDLE; o_running = state == RUN.

Reset
REQ-019 On i_rst: state IDLE, o_core_rst=1, o_core_ce=0, o_adc_ready=0, o_ecg_signal=0, o_ecg_signal_valid=0, o_ctr=0, FIFO empty, o_res_valid=0, result data 0, o_timeout=0, o_overflow=0, o_restart_cnt=0, o_busy=0, o_running=0.
REQ-020 i_rst mid-operation SHALL abandon any in-flight sample and take effect next edge regardless of other inputs.

Structure
REQ-021 A shared package SHALL hold the FSM state enum and the result record type {rr_period, rpeak_location}.
REQ-022 The result FIFO SHALL be one sub-module, res_fifo, parameterised on depth and record width.

Verification
REQ-023 Start, 4-cycle reset, feed samples with i_th_initialised after 10 -> o_core_rst high exactly 4 cycles, RUN after 10th sample, o_ctr=10.
REQ-024 i_adc_valid held high continuously -> o_ecg_signal_valid every other cycle, o_ctr consecutive, no sample lost or duplicated.
REQ-025 RUN, no RR update for 720 samples -> o_timeout one pulse, o_restart_cnt=1, o_ctr=0 after RECOVER, back to WARMUP.
REQ-026 Six RR updates with i_res_ready=0 -> four entries kept in order, o_overflow=1; then ready=1 drains exactly four.
REQ-027 FIFO full, push and pop same cycle -> count stays 4, o_overflow stays 0.
REQ-028 i_start and i_stop same cycle in IDLE, and i_stop mid-WARMUP -> IDLE, o_adc_ready=0, o_core_rst=1 next cycle.

Source files
------------

// File: rtl/alg_sequencer_pkg.sv
// Shared types for the ECG detection-core sequencer: FSM states and the RR result record.
package alg_sequencer_pkg;

  localparam int unsigned ResCtrWidth = 22;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StWarmup,
    StRun,
    StRecover
  } state_e;

  typedef struct packed {
    logic [ResCtrWidth-1:0] rr_period;
    logic [ResCtrWidth-1:0] rpeak_location;
  } res_t;

endpackage

// File: rtl/res_fifo.sv
// Result FIFO: valid/ready output stream, push-when-full dropped unless a pop frees a slot.
module res_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 44
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  output logic             drop_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] pop_data_o
);

  // Depth must be a power of two, at least 2.
  localparam int unsigned AddrWidth = $clog2(Depth);

  logic [Width-1:0]   mem_q [Depth];
  logic [AddrWidth:0] wr_ptr_q, rd_ptr_q;
  logic               empty, full, pop, push_ok;

  assign empty   = wr_ptr_q == rd_ptr_q;
  assign full    = (wr_ptr_q[AddrWidth] != rd_ptr_q[AddrWidth]) &&
                   (wr_ptr_q[AddrWidth-1:0] == rd_ptr_q[AddrWidth-1:0]);
  assign valid_o = !empty;
  assign pop     = valid_o && ready_i;
  // A same-cycle pop frees the slot the push lands in.
  assign push_ok = push_i && (!full || pop);
  assign drop_o  = push_i && !push_ok;

  assign pop_data_o = mem_q[rd_ptr_q[AddrWidth-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[AddrWidth-1:0]] <= push_data_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alg_sequencer.sv
// Sequences the ECG R-peak detection core: reset/warm-up, sample pacing, watchdog restart,
// and buffering of RR results.
module alg_sequencer
  import alg_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 11,
  parameter int unsigned CTR_WIDTH       = ResCtrWidth,
  parameter int unsigned TIMEOUT_SAMPLES = 720,
  parameter int unsigned CORE_RST_CYCLES = 4,
  parameter int unsigned RES_DEPTH       = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic signed [DATA_WIDTH-1:0] i_adc_data,
  input  logic                         i_adc_valid,
  output logic                         o_adc_ready,
  output logic signed [DATA_WIDTH-1:0] o_ecg_signal,
  output logic                         o_ecg_signal_valid,
  output logic [CTR_WIDTH-1:0]         o_ctr,
  output logic                         o_core_rst,
  output logic                         o_core_ce,
  input  logic                         i_th_initialised,
  input  logic                         i_rr_period_updated,
  input  logic [CTR_WIDTH-1:0]         i_rr_period,
  input  logic [CTR_WIDTH-1:0]         i_rpeak_location,
  output logic                         o_res_valid,
  input  logic                         i_res_ready,
  output logic [CTR_WIDTH-1:0]         o_res_rr_period,
  output logic [CTR_WIDTH-1:0]         o_res_rpeak_location,
  output logic                         o_busy,
  output logic                         o_running,
  output logic                         o_timeout,
  output logic                         o_overflow,
  output logic [7:0]                   o_restart_cnt
);

  localparam int unsigned RstCntWidth = $clog2(CORE_RST_CYCLES + 1);
  localparam int unsigned WdWidth     = $clog2(TIMEOUT_SAMPLES + 1);

  state_e                  state_q, state_d;
  logic [RstCntWidth-1:0]  rst_cnt_q, rst_cnt_d;
  logic [WdWidth-1:0]      wd_q, wd_d;
  logic [CTR_WIDTH-1:0]    ctr_q, ctr_d;
  logic signed [DATA_WIDTH-1:0] ecg_q;
  logic                    ecg_valid_q, timeout_q;
  logic                    overflow_q, overflow_d;
  logic [7:0]              restart_q, restart_d;

  logic start_ok, forwarding, in_reset_phase, accept, rr_push, fifo_drop, to_recover;
  res_t push_rec, pop_rec;

  assign start_ok       = (state_q == StIdle) && i_start && !i_stop;
  assign forwarding     = (state_q == StWarmup) || (state_q == StRun);
  assign in_reset_phase = (state_q == StFlush) || (state_q == StRecover);
  // Ready drops for the cycle after each accepted sample.
  assign o_adc_ready    = forwarding && !ecg_valid_q;
  assign accept         = i_adc_valid && o_adc_ready;
  assign rr_push        = (state_q == StRun) && i_rr_period_updated;
  assign to_recover     = (state_q == StRun) && (state_d == StRecover);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d   = StFlush;
          rst_cnt_d = '0;
        end
      end
      StFlush, StRecover: begin
        if (rst_cnt_q == RstCntWidth'(CORE_RST_CYCLES - 1)) begin
          state_d = StWarmup;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StWarmup: begin
        if (i_th_initialised) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (wd_q >= WdWidth'(TIMEOUT_SAMPLES)) begin
          state_d   = StRecover;
          rst_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (i_stop && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    ctr_d      = ctr_q;
    wd_d       = wd_q;
    restart_d  = restart_q;
    overflow_d = overflow_q;
    if (in_reset_phase) begin
      ctr_d = '0;
      wd_d  = '0;
    end else begin
      if (accept) begin
        ctr_d = ctr_q + 1'b1;
      end
      if (i_rr_period_updated) begin
        wd_d = '0;
      end else if (accept && (state_q == StRun)) begin
        wd_d = wd_q + 1'b1;
      end
    end
    if (start_ok) begin
      restart_d  = '0;
      overflow_d = 1'b0;
    end
    if (to_recover && (restart_q != 8'hFF)) begin
      restart_d = restart_q + 1'b1;
    end
    if (fifo_drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      rst_cnt_q   <= '0;
      wd_q        <= '0;
      ctr_q       <= '0;
      ecg_q       <= '0;
      ecg_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      restart_q   <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      wd_q        <= wd_d;
      ctr_q       <= ctr_d;
      ecg_valid_q <= accept;
      timeout_q   <= to_recover;
      overflow_q  <= overflow_d;
      restart_q   <= restart_d;
      if (accept) begin
        ecg_q <= i_adc_data;
      end
    end
  end

  assign push_rec.rr_period      = i_rr_period;
  assign push_rec.rpeak_location = i_rpeak_location;

  res_fifo #(
    .Depth(RES_DEPTH),
    .Width($bits(res_t))
  ) u_res_fifo (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .push_i     (rr_push),
    .push_data_i(push_rec),
    .drop_o     (fifo_drop),
    .valid_o    (o_res_valid),
    .ready_i    (i_res_ready),
    .pop_data_o (pop_rec)
  );

  assign o_res_rr_period      = pop_rec.rr_period;
  assign o_res_rpeak_location = pop_rec.rpeak_location;

  assign o_ecg_signal       = ecg_q;
  assign o_ecg_signal_valid = ecg_valid_q;
  assign o_ctr              = ctr_q;
  assign o_core_rst         = !forwarding;
  assign o_core_ce          = forwarding;
  assign o_busy             = state_q != StIdle;
  assign o_running          = state_q == StRun;
  assign o_timeout          = timeout_q;
  assign o_overflow         = overflow_q;
  assign o_restart_cnt      = restart_q;

endmodule

// File: tb/tb_alg_sequencer.sv
// Directed bench for alg_sequencer: start-up, pacing, FIFO full/overflow, watchdog, stop, reset.
module tb_alg_sequencer;

  logic               clk = 1'b0;
  logic               rst, start, stop;
  logic signed [10:0] adc_data, ecg;
  logic               adc_valid, adc_ready, ecg_valid;
  logic [21:0]        ctr, rr_period, rpeak, res_rr, res_rpeak;
  logic               core_rst, core_ce, th_init, rr_upd;
  logic               res_valid, res_ready, busy, running, timeout, overflow;
  logic [7:0]         restart_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [10:0] vec [10] = '{11'sd5, -11'sd3, 11'sd1023, -11'sd1024, 11'sd0,
                                   11'sd77, -11'sd300, 11'sd512, 11'sd1, -11'sd1};

  always #5 clk = ~clk;

  alg_sequencer dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_start             (start),
    .i_stop              (stop),
    .i_adc_data          (adc_data),
    .i_adc_valid         (adc_valid),
    .o_adc_ready         (adc_ready),
    .o_ecg_signal        (ecg),
    .o_ecg_signal_valid  (ecg_valid),
    .o_ctr               (ctr),
    .o_core_rst          (core_rst),
    .o_core_ce           (core_ce),
    .i_th_initialised    (th_init),
    .i_rr_period_updated (rr_upd),
    .i_rr_period         (rr_period),
    .i_rpeak_location    (rpeak),
    .o_res_valid         (res_valid),
    .i_res_ready         (res_ready),
    .o_res_rr_period     (res_rr),
    .o_res_rpeak_location(res_rpeak),
    .o_busy              (busy),
    .o_running           (running),
    .o_timeout           (timeout),
    .o_overflow          (overflow),
    .o_restart_cnt       (restart_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic signed [10:0] d);
    int n = 0;
    adc_valid = 1'b1;
    adc_data  = d;
    while (!adc_ready && n < 20) begin
      step();
      n++;
    end
    check_eq("ready_wait", 64'(n < 20), 64'd1);
    step();
    check_eq("fwd_valid", 64'(ecg_valid), 64'd1);
    check_eq("fwd_data", 64'(ecg), 64'(d));
    adc_valid = 1'b0;
  endtask

  task automatic push_rr(input int p, input int l);
    rr_upd    = 1'b1;
    rr_period = 22'(p);
    rpeak     = 22'(l);
    step();
    rr_upd    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int n_acc;
    rst = 1'b1; start = 1'b0; stop = 1'b0; adc_data = '0; adc_valid = 1'b0;
    th_init = 1'b0; rr_upd = 1'b0; rr_period = '0; rpeak = '0; res_ready = 1'b0;
    step();
    step();
    check_eq("rst_core_rst", 64'(core_rst), 64'd1);
    check_eq("rst_core_ce", 64'(core_ce), 64'd0);
    check_eq("rst_adc_ready", 64'(adc_ready), 64'd0);
    check_eq("rst_ecg", 64'(ecg), 64'd0);
    check_eq("rst_ecg_valid", 64'(ecg_valid), 64'd0);
    check_eq("rst_ctr", 64'(ctr), 64'd0);
    check_eq("rst_res_valid", 64'(res_valid), 64'd0);
    check_eq("rst_res_data", 64'({res_rr, res_rpeak}), 64'd0);
    check_eq("rst_flags", 64'({timeout, overflow, busy, running}), 64'd0);
    check_eq("rst_restart", 64'(restart_cnt), 64'd0);
    rst = 1'b0;
    step();

    // Start-up: core reset pulse length, then warm-up with 10 samples.
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (core_rst && n < 20) begin
      n++;
      step();
    end
    check_eq("flush_len", 64'(n), 64'd4);
    check_eq("warm_ce", 64'(core_ce), 64'd1);
    check_eq("warm_busy_run", 64'({busy, running}), 64'b10);
    for (int i = 0; i < 10; i++) begin
      send_sample(vec[i]);
    end
    check_eq("ctr_after_10", 64'(ctr), 64'd10);
    th_init = 1'b1;
    step();
    check_eq("run_entered", 64'(running), 64'd1);
    check_eq("valid_one_cycle", 64'(ecg_valid), 64'd0);
    check_eq("ecg_held", 64'(ecg), 64'(vec[9]));
    check_eq("ctr_held", 64'(ctr), 64'd10);

    // Continuous valid: one sample every other cycle, consecutive counter.
    adc_valid = 1'b1;
    adc_data  = 11'sd100;
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("stream_valid", 64'(ecg_valid), 64'(i % 2 == 0));
      check_eq("stream_ready", 64'(adc_ready), 64'(i % 2 != 0));
      if (i % 2 == 0) begin
        check_eq("stream_data", 64'(ecg), 64'(100 + i / 2));
        check_eq("stream_ctr", 64'(ctr), 64'(11 + i / 2));
        adc_data = 11'(100 + i / 2 + 1);
      end
    end
    adc_valid = 1'b0;

    // FIFO full with simultaneous push and pop: nothing lost, no overflow.
    for (int k = 0; k < 4; k++) begin
      push_rr(1100 + k, 2100 + k);
    end
    res_ready = 1'b1;
    push_rr(1104, 2104);
    check_eq("pp_no_overflow", 64'(overflow), 64'd0);
    for (int j = 0; j < 4; j++) begin
      check_eq("pp_valid", 64'(res_valid), 64'd1);
      check_eq("pp_rr", 64'(res_rr), 64'(1101 + j));
      check_eq("pp_loc", 64'(res_rpeak), 64'(2101 + j));
      step();
    end
    check_eq("pp_empty", 64'(res_valid), 64'd0);
    res_ready = 1'b0;

    // Six pushes into a four-entry FIFO: first four kept, overflow sticky.
    for (int k = 0; k < 6; k++) begin
      push_rr(1000 + k, 2000 + k);
    end
    check_eq("ovf_set", 64'(overflow), 64'd1);
    res_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check_eq("ovf_valid", 64'(res_valid), 64'd1);
      check_eq("ovf_rr", 64'(res_rr), 64'(1000 + j));
      check_eq("ovf_loc", 64'(res_rpeak), 64'(2000 + j));
      step();
    end
    check_eq("ovf_drained", 64'(res_valid), 64'd0);
    res_ready = 1'b0;
    push_rr(3000, 4000);

    // Watchdog: 720 samples without an RR update forces a restart.
    adc_valid = 1'b1;
    adc_data  = 11'sd7;
    n = 0;
    n_acc = 0;
    while (!timeout && n < 1600) begin
      step();
      n++;
      if (ecg_valid) n_acc++;
    end
    adc_valid = 1'b0;
    check_eq("wd_timeout", 64'(timeout), 64'd1);
    check_eq("wd_samples", 64'(n_acc), 64'd720);
    check_eq("wd_restart", 64'(restart_cnt), 64'd1);
    check_eq("wd_core_rst", 64'(core_rst), 64'd1);
    step();
    check_eq("wd_pulse_once", 64'(timeout), 64'd0);
    n = 1;
    while (core_rst && n < 20) begin
      n++;
      step();
    end
    check_eq("recover_len", 64'(n), 64'd4);
    check_eq("recover_ctr", 64'(ctr), 64'd0);
    check_eq("recover_warm", 64'({busy, running, core_ce}), 64'b101);

    // Stop mid-warm-up; FIFO entry survives recover and idle.
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("stop_idle", 64'({busy, adc_ready, core_rst}), 64'b001);
    check_eq("fifo_keep_rr", 64'({res_valid, res_rr}), {41'd0, 1'b1, 22'd3000});
    check_eq("fifo_keep_loc", 64'(res_rpeak), 64'd4000);
    start = 1'b1;
    stop  = 1'b1;
    step();
    stop  = 1'b0;
    check_eq("stop_wins", 64'({busy, adc_ready, core_rst}), 64'b001);
    step();
    start = 1'b0;
    check_eq("start_busy", 64'(busy), 64'd1);
    check_eq("start_clr_restart", 64'(restart_cnt), 64'd0);
    check_eq("start_clr_ovf", 64'(overflow), 64'd0);
    check_eq("start_fifo_kept", 64'(res_valid), 64'd1);

    // Reset during a sample handshake abandons the sample and empties the FIFO.
    n = 0;
    while (!adc_ready && n < 20) begin
      step();
      n++;
    end
    check_eq("pre_rst_ready", 64'(adc_ready), 64'd1);
    adc_valid = 1'b1;
    adc_data  = 11'sd55;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    adc_valid = 1'b0;
    check_eq("mid_rst_valid", 64'(ecg_valid), 64'd0);
    check_eq("mid_rst_ecg", 64'(ecg), 64'd0);
    check_eq("mid_rst_ctr", 64'(ctr), 64'd0);
    check_eq("mid_rst_state", 64'({busy, core_rst, res_valid}), 64'b010);
    check_eq("mid_rst_res", 64'({res_rr, res_rpeak}), 64'd0);
    step();
    check_eq("mid_rst_no_fwd", 64'(ecg_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
